core_periphs_mmio: RTL and testbench
====================================

Name: core_periphs_mmio

Overview:
- Parametrised successor to the core-to-memory periphery wrapper.
- Sits between the core's ideal-width memory port and the narrow on-chip RAM. Truncates in-range addresses to ACTUAL_ADDR_W and decodes a memory-mapped IO window of NUM_IO_CH 64-bit channel registers.
- Returns load data with a fixed, tracked latency plus a valid strobe.
- Records out-of-range accesses in a sticky fault register instead of silently aliasing them.

Parameters:
DATA_W, 64, data bus width; multiple of 8
ADDR_W, 64, core-side address width
ACTUAL_ADDR_W, 13, RAM byte-address width; RAM window is [0, 2**ACTUAL_ADDR_W)
LOAD_LATENCY, 1, RAM read latency in cycles; legal range 1..4
IO_BASE, 'h8000_0000, byte base of the IO window; DATA_W/8-aligned; must be >= 2**ACTUAL_ADDR_W
NUM_IO_CH, 4, number of IO channels; legal range 1..16; channel stride DATA_W/8 bytes

Ports:
clk  in  1  clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
core_addr  in  ADDR_W  byte address from core
core_re  in  1  load request, one cycle per load
core_we  in  DATA_W/8  byte-lane store enables
core_st_data  in  DATA_W  store data
core_ld_data  out  DATA_W  load return data
core_ld_valid  out  1  core_ld_data valid strobe
mem_addr  out  ACTUAL_ADDR_W  RAM address
mem_we  out  DATA_W/8  RAM byte enables
mem_st_data  out  DATA_W  RAM store data
mem_ld_data  in  DATA_W  RAM read data, LOAD_LATENCY cycles after address
io_in  in  NUM_IO_CH*DATA_W  channel read values; channel k at bits [k*DATA_W +: DATA_W]
io_out  out  NUM_IO_CH*DATA_W  channel write registers
io_wr  out  NUM_IO_CH  one-cycle pulse per channel written
fault  out  1  sticky out-of-range flag
fault_addr  out  ADDR_W  address of the first faulting access
fault_clr  in  1  clears fault

Behaviour:
- Decode (combinational, per cycle):
  - RAM if core_addr < 2**ACTUAL_ADDR_W.
  - IO if IO_BASE <= core_addr < IO_BASE + NUM_IO_CH*DATA_W/8; channel = (core_addr - IO_BASE) / (DATA_W/8); low address bits are ignored.
  - Otherwise FAULT.
  - An access is a cycle with core_re=1 or core_we!=0.
- RAM path:
  - mem_addr = core_addr[ACTUAL_ADDR_W-1:0] always.
  - mem_st_data = core_st_data.
  - mem_we = core_we only when the decode is RAM, else 0. Combinational, zero latency.
- IO store: on a clock edge with decode IO and core_we!=0, update only the enabled byte lanes of the selected channel's io_out register. Assert that channel's io_wr for exactly the following cycle.
- Load pipeline:
  - LOAD_LATENCY-stage shift register carrying {valid, source RAM/IO/FAULT, captured IO word}.
  - For an IO load, io_in of the selected channel is sampled in the issue cycle.
  - core_ld_valid=1 exactly LOAD_LATENCY cycles after the core_re cycle.
  - core_ld_data on that cycle: source RAM gives mem_ld_data; IO gives the captured word; FAULT gives 0.
  - core_ld_data holds its last value when core_ld_valid=0.
  - Back-to-back loads every cycle are supported; each returns in order.
- Simultaneous core_re and core_we to the same IO channel: the load returns the io_in sample, not the stored value.
- Fault register:
  - On a FAULT-decoded access with fault=0: set fault=1 and capture fault_addr=core_addr.
  - Further faults while fault=1 do not change fault_addr.
  - fault_clr=1 clears fault next edge. fault_addr keeps its value.
  - fault_clr in the same cycle as a new fault: fault stays 1 and fault_addr takes the new address.
- Reset:
  - Asynchronous; clears all pipeline valids, io_out, io_wr, core_ld_data, core_ld_valid, fault and fault_addr to 0.
  - Loads in flight at reset are discarded and never produce core_ld_valid.
  - mem_we is 0 during reset regardless of core_we.
- Wrap/boundary:
  - Address 2**ACTUAL_ADDR_W exactly is FAULT, never aliased to RAM address 0.
  - Last byte of the IO window is IO; the next byte is FAULT.

Test Plan:
- Reset, then store 'hDEAD_BEEF with core_we='hFF at addr 'h10, then core_re at 'h10 -> mem_we='hFF in the store cycle; core_ld_valid exactly LOAD_LATENCY cycles later with core_ld_data = RAM model value 'hDEAD_BEEF.
- Store core_st_data='h1122_3344_5566_7788 with core_we='h0F to IO_BASE+8 -> io_out ch1 = 'h0000_0000_5566_7788; io_wr=4'b0010 for one cycle; mem_we=0.
- Load at IO_BASE+24 with io_in ch3='hABCD, then change io_in -> returns 'hABCD after LOAD_LATENCY.
- Store at 'h2000 (ACTUAL_ADDR_W=13), then a load at 'h3000 -> fault=1, fault_addr='h2000, mem_we=0; the load returns 0 with valid. Then fault_clr together with a store to 'h4000 -> fault=1, fault_addr='h4000.
- Issue core_re on 3 consecutive cycles with LOAD_LATENCY=2; assert rst in the cycle after the last issue -> no core_ld_valid at any point after rst; all outputs 0.
- Sweep LOAD_LATENCY 1..4 with back-to-back RAM/IO/FAULT loads -> in-order returns, one valid per request, correct sources.

Source files
------------

// File: rtl/core_periphs_mmio.sv
// Core-to-RAM periphery: truncates RAM addresses, decodes an IO channel window,
// returns loads after a fixed tracked latency and latches out-of-range accesses.
module core_periphs_mmio #(
  parameter int                DATA_W        = 64,
  parameter int                ADDR_W        = 64,
  parameter int                ACTUAL_ADDR_W = 13,
  parameter int                LOAD_LATENCY  = 1,
  parameter logic [ADDR_W-1:0] IO_BASE       = 'h8000_0000,
  parameter int                NUM_IO_CH     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [ADDR_W-1:0]           core_addr,
  input  logic                        core_re,
  input  logic [DATA_W/8-1:0]         core_we,
  input  logic [DATA_W-1:0]           core_st_data,
  output logic [DATA_W-1:0]           core_ld_data,
  output logic                        core_ld_valid,
  output logic [ACTUAL_ADDR_W-1:0]    mem_addr,
  output logic [DATA_W/8-1:0]         mem_we,
  output logic [DATA_W-1:0]           mem_st_data,
  input  logic [DATA_W-1:0]           mem_ld_data,
  input  logic [NUM_IO_CH*DATA_W-1:0] io_in,
  output logic [NUM_IO_CH*DATA_W-1:0] io_out,
  output logic [NUM_IO_CH-1:0]        io_wr,
  output logic                        fault,
  output logic [ADDR_W-1:0]           fault_addr,
  input  logic                        fault_clr
);

  localparam int                BYTES   = DATA_W / 8;
  localparam int                CH_W    = (NUM_IO_CH > 1) ? $clog2(NUM_IO_CH) : 1;
  localparam logic [ADDR_W-1:0] IO_SPAN = ADDR_W'(NUM_IO_CH * BYTES);
  localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(BYTES);

  typedef enum logic [1:0] {
    SRC_FAULT = 2'd0,
    SRC_RAM   = 2'd1,
    SRC_IO    = 2'd2
  } src_e;

  logic              w_is_ram;
  logic              w_is_io;
  logic              w_access;
  logic              w_fault_hit;
  logic              w_io_st;
  logic [ADDR_W-1:0] w_io_off;
  logic [CH_W-1:0]   w_ch;
  logic [DATA_W-1:0] w_io_rd;
  src_e              w_src;
  logic              w_last_v;
  logic [DATA_W-1:0] w_ld_now;

  logic              r_pv    [LOAD_LATENCY];
  src_e              r_psrc  [LOAD_LATENCY];
  logic [DATA_W-1:0] r_pword [LOAD_LATENCY];
  logic [DATA_W-1:0]           r_ld_hold;
  logic [NUM_IO_CH*DATA_W-1:0] r_io_out;
  logic [NUM_IO_CH-1:0]        r_io_wr;
  logic                        r_fault;
  logic [ADDR_W-1:0]           r_fault_addr;

  // Any set bit above the RAM window is out of RAM, so 2**ACTUAL_ADDR_W never aliases to 0.
  assign w_is_ram    = ~|core_addr[ADDR_W-1:ACTUAL_ADDR_W];
  assign w_io_off    = core_addr - IO_BASE;
  assign w_is_io     = !w_is_ram && (core_addr >= IO_BASE) && (w_io_off < IO_SPAN);
  assign w_ch        = CH_W'(w_io_off / BYTES_A);
  assign w_access    = core_re || (|core_we);
  assign w_fault_hit = w_access && !w_is_ram && !w_is_io;
  assign w_io_st     = w_is_io && (|core_we);
  assign w_src       = w_is_ram ? SRC_RAM : (w_is_io ? SRC_IO : SRC_FAULT);

  assign mem_addr    = core_addr[ACTUAL_ADDR_W-1:0];
  assign mem_st_data = core_st_data;
  assign mem_we      = (w_is_ram && !rst) ? core_we : '0;

  always_comb begin
    w_io_rd = '0;
    for (int k = 0; k < NUM_IO_CH; k++) begin
      if (w_ch == CH_W'(k)) w_io_rd = io_in[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LOAD_LATENCY; i++) begin
        r_pv[i]    <= 1'b0;
        r_psrc[i]  <= SRC_FAULT;
        r_pword[i] <= '0;
      end
    end else begin
      r_pv[0]    <= core_re;
      r_psrc[0]  <= w_src;
      r_pword[0] <= w_is_io ? w_io_rd : '0;
      for (int i = 1; i < LOAD_LATENCY; i++) begin
        r_pv[i]    <= r_pv[i-1];
        r_psrc[i]  <= r_psrc[i-1];
        r_pword[i] <= r_pword[i-1];
      end
    end
  end

  // RAM data arrives combinationally in the return cycle, so the return mux sits after the pipe.
  assign w_last_v = r_pv[LOAD_LATENCY-1];

  always_comb begin
    case (r_psrc[LOAD_LATENCY-1])
      SRC_RAM: w_ld_now = mem_ld_data;
      SRC_IO:  w_ld_now = r_pword[LOAD_LATENCY-1];
      default: w_ld_now = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ld_hold <= '0;
    end else if (w_last_v) begin
      r_ld_hold <= w_ld_now;
    end
  end

  assign core_ld_valid = w_last_v;
  assign core_ld_data  = w_last_v ? w_ld_now : r_ld_hold;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_io_out <= '0;
      r_io_wr  <= '0;
    end else begin
      for (int k = 0; k < NUM_IO_CH; k++) begin
        r_io_wr[k] <= w_io_st && (w_ch == CH_W'(k));
        for (int b = 0; b < BYTES; b++) begin
          if (w_io_st && (w_ch == CH_W'(k)) && core_we[b]) begin
            r_io_out[k*DATA_W + b*8 +: 8] <= core_st_data[b*8 +: 8];
          end
        end
      end
    end
  end

  assign io_out = r_io_out;
  assign io_wr  = r_io_wr;

  // A new fault wins over a same-cycle clear and re-arms the captured address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fault      <= 1'b0;
      r_fault_addr <= '0;
    end else if (w_fault_hit && (!r_fault || fault_clr)) begin
      r_fault      <= 1'b1;
      r_fault_addr <= core_addr;
    end else if (fault_clr) begin
      r_fault <= 1'b0;
    end
  end

  assign fault      = r_fault;
  assign fault_addr = r_fault_addr;

endmodule

// File: tb/tb_core_periphs_mmio.sv
// Directed bench: four instances at LOAD_LATENCY 1..4 share one stimulus stream,
// each with its own RAM model and load-return checker.
module tb_core_periphs_mmio;

  localparam logic [63:0] IO_BASE = 64'h8000_0000;

  logic         clk;
  logic         rst;
  logic [63:0]  core_addr;
  logic         core_re;
  logic [7:0]   core_we;
  logic [63:0]  core_st_data;
  logic [255:0] io_in;
  logic         fault_clr;

  logic [63:0]  ld_data_a  [4];
  logic         ld_valid_a [4];
  logic [12:0]  mem_addr_a [4];
  logic [7:0]   mem_we_a   [4];
  logic [63:0]  mem_st_a   [4];
  logic [63:0]  mem_ld_a   [4];
  logic [255:0] io_out_a   [4];
  logic [3:0]   io_wr_a    [4];
  logic         fault_a    [4];
  logic [63:0]  faddr_a    [4];

  int total;
  int bad;
  int cyc;
  int rst_rel;
  bit        exp_v [1024];
  bit [63:0] exp_d [1024];
  bit [63:0] ref_mem [1024];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int L = g + 1;
    bit [63:0]   m  [1024];
    bit [63:0]   rp [L];
    logic [63:0] hold;
    int          c;
    bit          ev;

    core_periphs_mmio #(.LOAD_LATENCY(L)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .core_addr    (core_addr),
      .core_re      (core_re),
      .core_we      (core_we),
      .core_st_data (core_st_data),
      .core_ld_data (ld_data_a[g]),
      .core_ld_valid(ld_valid_a[g]),
      .mem_addr     (mem_addr_a[g]),
      .mem_we       (mem_we_a[g]),
      .mem_st_data  (mem_st_a[g]),
      .mem_ld_data  (mem_ld_a[g]),
      .io_in        (io_in),
      .io_out       (io_out_a[g]),
      .io_wr        (io_wr_a[g]),
      .fault        (fault_a[g]),
      .fault_addr   (faddr_a[g]),
      .fault_clr    (fault_clr)
    );

    assign mem_ld_a[g] = rp[L-1];

    always @(posedge clk) begin
      for (int b = 0; b < 8; b++)
        if (mem_we_a[g][b]) m[mem_addr_a[g][12:3]][b*8 +: 8] <= mem_st_a[g][b*8 +: 8];
      rp[0] <= m[mem_addr_a[g][12:3]];
      for (int i = 1; i < L; i++) rp[i] <= rp[i-1];
    end

    // Issue cycle c returns in cycle c+L unless a reset arrived after it was issued.
    always @(negedge clk) begin
      c  = cyc - L;
      ev = 1'b0;
      if (c >= 0 && c >= rst_rel) ev = exp_v[c];
      if (rst) begin
        hold = '0;
        chk($sformatf("rst_valid_L%0d", L), {63'd0, ld_valid_a[g]}, 64'd0);
        chk($sformatf("rst_data_L%0d", L), ld_data_a[g], 64'd0);
      end else begin
        chk($sformatf("ld_valid_L%0d", L), {63'd0, ld_valid_a[g]}, {63'd0, ev});
        if (ev) hold = exp_d[c];
        chk($sformatf("ld_data_L%0d", L), ld_data_a[g], hold);
      end
    end
  end

  function automatic logic [63:0] ref_load(input logic [63:0] a);
    if (a < 64'h2000) return ref_mem[a[12:3]];
    if (a >= IO_BASE && a < IO_BASE + 64'd32) return io_in[int'((a - IO_BASE) >> 3) * 64 +: 64];
    return 64'd0;
  endfunction

  task automatic drive(input logic [63:0] a, input bit re, input logic [7:0] we, input logic [63:0] d);
    core_addr    = a;
    core_re      = re;
    core_we      = we;
    core_st_data = d;
    if (re) begin
      exp_v[cyc] = 1'b1;
      exp_d[cyc] = ref_load(a);
    end
    if (we != 8'h00 && a < 64'h2000) begin
      for (int b = 0; b < 8; b++)
        if (we[b]) ref_mem[a[12:3]][b*8 +: 8] = d[b*8 +: 8];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    drive(64'd0, 1'b0, 8'h00, 64'd0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; rst_rel = 0;
    rst = 1'b1; fault_clr = 1'b0; io_in = '0;
    core_addr = 64'h10; core_re = 1'b0; core_we = 8'hFF; core_st_data = 64'h1;
    #1;
    chk("rst_mem_we", {56'd0, mem_we_a[0]}, 64'd0);
    tick(); tick();
    chk("rst_fault", {63'd0, fault_a[0]}, 64'd0);
    chk("rst_faddr", faddr_a[0], 64'd0);
    chk("rst_io_wr", {60'd0, io_wr_a[0]}, 64'd0);
    core_we = 8'h00;
    rst = 1'b0; rst_rel = cyc;

    // RAM store then load
    drive(64'h10, 1'b0, 8'hFF, 64'hDEAD_BEEF); #1;
    chk("ram_mem_we", {56'd0, mem_we_a[0]}, 64'hFF);
    tick();
    drive(64'h10, 1'b1, 8'h00, 64'd0); tick();
    idle(5);

    // IO partial-lane store to ch1
    drive(IO_BASE + 64'd8, 1'b0, 8'h0F, 64'h1122_3344_5566_7788); #1;
    chk("io_mem_we", {56'd0, mem_we_a[0]}, 64'd0);
    tick();
    chk("io_wr_pulse", {60'd0, io_wr_a[0]}, 64'h2);
    chk("io_out_ch1", io_out_a[0][127:64], 64'h0000_0000_5566_7788);
    idle(1);
    chk("io_wr_drop", {60'd0, io_wr_a[0]}, 64'd0);
    chk("io_out_hold", io_out_a[0][127:64], 64'h0000_0000_5566_7788);

    // IO load samples io_in in the issue cycle
    io_in[3*64 +: 64] = 64'hABCD;
    drive(IO_BASE + 64'd24, 1'b1, 8'h00, 64'd0); tick();
    io_in[3*64 +: 64] = 64'h1234;
    idle(5);

    // Fault capture, sticky address, clear racing a new fault
    drive(64'h2000, 1'b0, 8'hFF, 64'h55); #1;
    chk("flt_mem_we", {56'd0, mem_we_a[0]}, 64'd0);
    tick();
    chk("flt_set", {63'd0, fault_a[0]}, 64'd1);
    chk("flt_addr", faddr_a[0], 64'h2000);
    drive(64'h3000, 1'b1, 8'h00, 64'd0); tick();
    chk("flt_sticky", faddr_a[0], 64'h2000);
    fault_clr = 1'b1;
    drive(64'h4000, 1'b0, 8'h01, 64'd0); tick();
    chk("flt_clr_new", {63'd0, fault_a[0]}, 64'd1);
    chk("flt_clr_addr", faddr_a[0], 64'h4000);
    idle(1);
    fault_clr = 1'b0;
    chk("flt_cleared", {63'd0, fault_a[0]}, 64'd0);
    chk("flt_addr_keep", faddr_a[0], 64'h4000);
    idle(4);

    // Window edges
    drive(64'h1FF8, 1'b0, 8'hFF, 64'hCAFE_F00D); #1;
    chk("ram_top_we", {56'd0, mem_we_a[0]}, 64'hFF);
    tick();
    drive(64'h1FFF, 1'b1, 8'h00, 64'd0); tick();
    io_in[3*64 +: 64] = 64'h77;
    drive(IO_BASE + 64'd31, 1'b1, 8'h00, 64'd0); tick();
    chk("io_last_ok", {63'd0, fault_a[0]}, 64'd0);
    drive(IO_BASE + 64'd32, 1'b1, 8'h00, 64'd0); tick();
    chk("io_past_flt", {63'd0, fault_a[0]}, 64'd1);
    chk("io_past_addr", faddr_a[0], IO_BASE + 64'd32);
    fault_clr = 1'b1;
    idle(1);
    fault_clr = 1'b0;
    idle(4);

    // Load and store to the same IO channel in one cycle
    io_in[2*64 +: 64] = 64'h9999;
    drive(IO_BASE + 64'd16, 1'b1, 8'hFF, 64'h4242); tick();
    chk("rw_io_out", io_out_a[0][191:128], 64'h4242);
    chk("rw_io_wr", {60'd0, io_wr_a[0]}, 64'h4);
    idle(5);

    // Back-to-back mixed sources
    io_in[0 +: 64]  = 64'h1010;
    io_in[64 +: 64] = 64'h2020;
    drive(64'h10, 1'b1, 8'h00, 64'd0);           tick();
    drive(IO_BASE, 1'b1, 8'h00, 64'd0);          tick();
    drive(64'h5000, 1'b1, 8'h00, 64'd0);         tick();
    drive(64'h1FF8, 1'b1, 8'h00, 64'd0);         tick();
    drive(IO_BASE + 64'd8, 1'b1, 8'h00, 64'd0);  tick();
    drive(64'h10, 1'b1, 8'h00, 64'd0);           tick();
    idle(6);

    // Reset with loads in flight
    drive(64'h10, 1'b1, 8'h00, 64'd0);   tick();
    drive(IO_BASE, 1'b1, 8'h00, 64'd0);  tick();
    drive(64'h1FF8, 1'b1, 8'h00, 64'd0); tick();
    drive(64'd0, 1'b0, 8'h00, 64'd0);
    rst = 1'b1; #1;
    chk("mid_rst_fault", {63'd0, fault_a[0]}, 64'd0);
    chk("mid_rst_faddr", faddr_a[0], 64'd0);
    chk("mid_rst_io_wr", {60'd0, io_wr_a[0]}, 64'd0);
    chk("mid_rst_io1", io_out_a[0][127:64], 64'd0);
    chk("mid_rst_io2", io_out_a[0][191:128], 64'd0);
    tick();
    rst = 1'b0; rst_rel = cyc;
    idle(6);

    drive(64'h1FF8, 1'b1, 8'h00, 64'd0); tick();
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
